controlador_microondas: RTL and testbench

//  Microwave oven controller: keypad time entry (M:SS), start/stop/door interlock, 1 s countdown, magnetron enable.

---
 rtl/controlador_microondas.sv | 124 ++++++++++++
 tb/tb_controlador_microondas.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/controlador_microondas.sv
// Microwave oven controller: keypad M:SS entry, start/stop/door interlock,
// one-second countdown, magnetron enable and three 7-segment digit drivers.
module controlador_microondas #(
  parameter int CLKS_PER_SEC = 100
) (
  input  logic       clk,
  input  logic       clearn,
  input  logic       startn,
  input  logic       stopn,
  input  logic       door_closed,
  input  logic [9:0] keypad,
  output logic       mag_on,
  output logic [0:6] min_segs,
  output logic [0:6] sec_tens_segs,
  output logic [0:6] sec_ones_segs
);

  typedef enum logic {IDLE, COOK} state_t;

  localparam int CW = (CLKS_PER_SEC > 2) ? $clog2(CLKS_PER_SEC) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_SEC - 1);

  state_t        state, state_n;
  logic [3:0]    mins, tens, ones;
  logic [3:0]    mins_n, tens_n, ones_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [9:0]    key_q;
  logic [9:0]    edges;
  logic [3:0]    key_d;
  logic          nonzero;

  assign edges   = keypad & ~key_q;
  assign nonzero = |{mins, tens, ones};

  // Highest rising key index wins when several rise together.
  always_comb begin
    key_d = '0;
    for (int i = 0; i < 10; i++)
      if (edges[i]) key_d = 4'(i);
  end

  always_comb begin
    state_n = state;
    mins_n  = mins;
    tens_n  = tens;
    ones_n  = ones;
    cnt_n   = cnt;
    unique case (state)
      IDLE: begin
        if (edges != '0) begin
          mins_n = tens;
          tens_n = ones;
          ones_n = key_d;
        end
        if (!startn && stopn && door_closed && nonzero) begin
          state_n = COOK;
          cnt_n   = '0;
        end
      end
      COOK: begin
        if (!stopn || !door_closed) begin
          state_n = IDLE;
        end else if (cnt == LAST) begin
          cnt_n = '0;
          if (ones != 4'd0) begin
            ones_n = ones - 4'd1;
          end else if (tens != 4'd0) begin
            tens_n = tens - 4'd1;
            ones_n = 4'd9;
          end else if (mins != 4'd0) begin
            mins_n = mins - 4'd1;
            tens_n = 4'd5;
            ones_n = 4'd9;
          end
          if ({mins_n, tens_n, ones_n} == 12'd0) state_n = IDLE;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clearn) begin
    if (!clearn) begin
      state  <= IDLE;
      mins   <= '0;
      tens   <= '0;
      ones   <= '0;
      cnt    <= '0;
      key_q  <= '0;
      mag_on <= 1'b0;
    end else begin
      state  <= state_n;
      mins   <= mins_n;
      tens   <= tens_n;
      ones   <= ones_n;
      cnt    <= cnt_n;
      key_q  <= keypad;
      mag_on <= (state_n == COOK);
    end
  end

  function automatic logic [0:6] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1111110;
      4'd1:    seg7 = 7'b0110000;
      4'd2:    seg7 = 7'b1101101;
      4'd3:    seg7 = 7'b1111001;
      4'd4:    seg7 = 7'b0110011;
      4'd5:    seg7 = 7'b1011011;
      4'd6:    seg7 = 7'b1011111;
      4'd7:    seg7 = 7'b1110000;
      4'd8:    seg7 = 7'b1111111;
      4'd9:    seg7 = 7'b1111011;
      default: seg7 = 7'b0000000;
    endcase
  endfunction

  assign min_segs      = seg7(mins);
  assign sec_tens_segs = seg7(tens);
  assign sec_ones_segs = seg7(ones);

endmodule

// File: tb/tb_controlador_microondas.sv
// Directed bench for controlador_microondas with a 4-cycle second.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_controlador_microondas;

  logic       clk = 1'b0;
  logic       clearn;
  logic       startn;
  logic       stopn;
  logic       door_closed;
  logic [9:0] keypad;
  logic       mag_on;
  logic [0:6] min_segs;
  logic [0:6] sec_tens_segs;
  logic [0:6] sec_ones_segs;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  controlador_microondas #(.CLKS_PER_SEC(4)) dut (
    .clk(clk),
    .clearn(clearn),
    .startn(startn),
    .stopn(stopn),
    .door_closed(door_closed),
    .keypad(keypad),
    .mag_on(mag_on),
    .min_segs(min_segs),
    .sec_tens_segs(sec_tens_segs),
    .sec_ones_segs(sec_ones_segs)
  );

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'b1111110;
      1: return 7'b0110000;
      2: return 7'b1101101;
      3: return 7'b1111001;
      4: return 7'b0110011;
      5: return 7'b1011011;
      6: return 7'b1011111;
      7: return 7'b1110000;
      8: return 7'b1111111;
      9: return 7'b1111011;
      default: return 7'b0000000;
    endcase
  endfunction

  function automatic logic [21:0] tm(input int m, input int t, input int o, input logic mg);
    return {seg_of(m), seg_of(t), seg_of(o), mg};
  endfunction

  function automatic logic [21:0] shown();
    return {min_segs, sec_tens_segs, sec_ones_segs, mag_on};
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input int k);
    keypad = 10'(1 << k);
    cyc(5);
    keypad = '0;
    cyc(2);
  endtask

  task automatic start_pulse();
    startn = 1'b0;
    cyc(1);
    startn = 1'b1;
  endtask

  task automatic test_reset();
    clearn = 1'b0; startn = 1'b1; stopn = 1'b1;
    door_closed = 1'b0; keypad = '0;
    #1;
    vectors++;
    if (shown() !== tm(0, 0, 0, 1'b0)) begin
      miscompares++;
      $display("FAIL reset: got %b want %b", shown(), tm(0, 0, 0, 1'b0));
    end
    cyc(2);
    clearn = 1'b1;
    cyc(2);
  endtask

  task automatic test_key_entry();
    press(1); press(4); press(8);
    vectors++;
    if (min_segs !== 7'b0110000 || sec_tens_segs !== 7'b0110011 ||
        sec_ones_segs !== 7'b1111111 || mag_on !== 1'b0) begin
      miscompares++;
      $display("FAIL keys_148: got %b want %b", shown(), tm(1, 4, 8, 1'b0));
    end
  endtask

  task automatic test_cook();
    door_closed = 1'b1;
    cyc(1);
    startn = 1'b0;
    cyc(1);
    vectors++;
    if (shown() !== tm(1, 4, 8, 1'b1)) begin
      miscompares++;
      $display("FAIL start_mag: got %b want %b", shown(), tm(1, 4, 8, 1'b1));
    end
    cyc(3);
    vectors++;
    if (shown() !== tm(1, 4, 8, 1'b1)) begin
      miscompares++;
      $display("FAIL pre_tick: got %b want %b", shown(), tm(1, 4, 8, 1'b1));
    end
    cyc(1);
    startn = 1'b1;
    vectors++;
    if (shown() !== tm(1, 4, 7, 1'b1)) begin
      miscompares++;
      $display("FAIL first_sec: got %b want %b", shown(), tm(1, 4, 7, 1'b1));
    end
    cyc(47 * 4);
    vectors++;
    if (shown() !== tm(1, 0, 0, 1'b1)) begin
      miscompares++;
      $display("FAIL at_1_00: got %b want %b", shown(), tm(1, 0, 0, 1'b1));
    end
    cyc(4);
    vectors++;
    if (shown() !== tm(0, 5, 9, 1'b1)) begin
      miscompares++;
      $display("FAIL borrow_059: got %b want %b", shown(), tm(0, 5, 9, 1'b1));
    end
    cyc(8 * 4);
    vectors++;
    if (shown() !== tm(0, 5, 1, 1'b1)) begin
      miscompares++;
      $display("FAIL at_0_51: got %b want %b", shown(), tm(0, 5, 1, 1'b1));
    end
  endtask

  task automatic test_stop_resume();
    stopn = 1'b0;
    cyc(1);
    stopn = 1'b1;
    vectors++;
    if (shown() !== tm(0, 5, 1, 1'b0)) begin
      miscompares++;
      $display("FAIL stop: got %b want %b", shown(), tm(0, 5, 1, 1'b0));
    end
    cyc(10);
    vectors++;
    if (shown() !== tm(0, 5, 1, 1'b0)) begin
      miscompares++;
      $display("FAIL frozen: got %b want %b", shown(), tm(0, 5, 1, 1'b0));
    end
    start_pulse();
    vectors++;
    if (shown() !== tm(0, 5, 1, 1'b1)) begin
      miscompares++;
      $display("FAIL resume: got %b want %b", shown(), tm(0, 5, 1, 1'b1));
    end
    cyc(203);
    vectors++;
    if (shown() !== tm(0, 0, 1, 1'b1)) begin
      miscompares++;
      $display("FAIL at_0_01: got %b want %b", shown(), tm(0, 0, 1, 1'b1));
    end
    cyc(1);
    vectors++;
    if (shown() !== tm(0, 0, 0, 1'b0)) begin
      miscompares++;
      $display("FAIL done: got %b want %b", shown(), tm(0, 0, 0, 1'b0));
    end
    cyc(8);
    vectors++;
    if (shown() !== tm(0, 0, 0, 1'b0)) begin
      miscompares++;
      $display("FAIL stay_idle: got %b want %b", shown(), tm(0, 0, 0, 1'b0));
    end
  endtask

  task automatic test_clear();
    press(2); press(5); press(0);
    vectors++;
    if (shown() !== tm(2, 5, 0, 1'b0)) begin
      miscompares++;
      $display("FAIL keys_250: got %b want %b", shown(), tm(2, 5, 0, 1'b0));
    end
    start_pulse();
    cyc(2);
    #2;
    clearn = 1'b0;
    #1;
    vectors++;
    if (shown() !== tm(0, 0, 0, 1'b0)) begin
      miscompares++;
      $display("FAIL async_clear: got %b want %b", shown(), tm(0, 0, 0, 1'b0));
    end
    cyc(1);
    clearn = 1'b1;
    cyc(1);
    press(3);
    vectors++;
    if (shown() !== tm(0, 0, 3, 1'b0)) begin
      miscompares++;
      $display("FAIL key_after_clr: got %b want %b", shown(), tm(0, 0, 3, 1'b0));
    end
  endtask

  task automatic test_door();
    press(2); press(7); press(5);
    vectors++;
    if (shown() !== tm(2, 7, 5, 1'b0)) begin
      miscompares++;
      $display("FAIL keys_275: got %b want %b", shown(), tm(2, 7, 5, 1'b0));
    end
    start_pulse();
    cyc(8);
    vectors++;
    if (shown() !== tm(2, 7, 3, 1'b1)) begin
      miscompares++;
      $display("FAIL cook_273: got %b want %b", shown(), tm(2, 7, 3, 1'b1));
    end
    door_closed = 1'b0;
    cyc(1);
    vectors++;
    if (shown() !== tm(2, 7, 3, 1'b0)) begin
      miscompares++;
      $display("FAIL door_open: got %b want %b", shown(), tm(2, 7, 3, 1'b0));
    end
    cyc(8);
    door_closed = 1'b1;
    cyc(8);
    vectors++;
    if (shown() !== tm(2, 7, 3, 1'b0)) begin
      miscompares++;
      $display("FAIL reclose: got %b want %b", shown(), tm(2, 7, 3, 1'b0));
    end
    start_pulse();
    cyc(4);
    vectors++;
    if (shown() !== tm(2, 7, 2, 1'b1)) begin
      miscompares++;
      $display("FAIL resume_272: got %b want %b", shown(), tm(2, 7, 2, 1'b1));
    end
    keypad = 10'(1 << 9);
    cyc(2);
    keypad = '0;
    cyc(1);
    vectors++;
    if (shown() !== tm(2, 7, 2, 1'b1)) begin
      miscompares++;
      $display("FAIL key_in_cook: got %b want %b", shown(), tm(2, 7, 2, 1'b1));
    end
    stopn = 1'b0;
    startn = 1'b0;
    cyc(1);
    vectors++;
    if (shown() !== tm(2, 7, 2, 1'b0)) begin
      miscompares++;
      $display("FAIL stop_wins: got %b want %b", shown(), tm(2, 7, 2, 1'b0));
    end
    cyc(3);
    vectors++;
    if (shown() !== tm(2, 7, 2, 1'b0)) begin
      miscompares++;
      $display("FAIL stop_held: got %b want %b", shown(), tm(2, 7, 2, 1'b0));
    end
    stopn = 1'b1;
    startn = 1'b1;
    cyc(1);
  endtask

  task automatic test_ignored();
    door_closed = 1'b0;
    startn = 1'b0;
    cyc(3);
    startn = 1'b1;
    vectors++;
    if (shown() !== tm(2, 7, 2, 1'b0)) begin
      miscompares++;
      $display("FAIL start_door_open: got %b want %b", shown(), tm(2, 7, 2, 1'b0));
    end
    clearn = 1'b0;
    cyc(1);
    clearn = 1'b1;
    door_closed = 1'b1;
    startn = 1'b0;
    cyc(3);
    startn = 1'b1;
    vectors++;
    if (shown() !== tm(0, 0, 0, 1'b0)) begin
      miscompares++;
      $display("FAIL start_zero: got %b want %b", shown(), tm(0, 0, 0, 1'b0));
    end
    keypad = 10'b0010001000;
    cyc(3);
    vectors++;
    if (shown() !== tm(0, 0, 7, 1'b0)) begin
      miscompares++;
      $display("FAIL multi_key: got %b want %b", shown(), tm(0, 0, 7, 1'b0));
    end
    keypad = 10'b0010101000;
    cyc(3);
    keypad = '0;
    cyc(2);
    vectors++;
    if (shown() !== tm(0, 7, 5, 1'b0)) begin
      miscompares++;
      $display("FAIL bit_edge: got %b want %b", shown(), tm(0, 7, 5, 1'b0));
    end
  endtask

  initial begin
    test_reset();
    test_key_entry();
    test_cook();
    test_stop_resume();
    test_clear();
    test_door();
    test_ignored();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
